// File: rtl/sap_sequencer.sv
// sap_sequencer
//   Controller/sequencer for the 8-bit bus computer. It steps through the
//   fetch (T1..T3) and execute (T4..T6) T-states and decodes the 4-bit
//   opcode. For ADD/SUB it inserts ALU_LAT wait cycles between the B-register
//   load and the accumulator load. This gives the registered ALU result time
//   to settle before the accumulator samples it.
//
//   Ports
//     CLK      system clock, rising edge
//     CLR_n    synchronous active-low reset (state -> T1, wait counter -> 0)
//     opcode   IR upper nibble
//     Cp Ep Lm CE Li Ei La Ea Lb Lo   bus load/enable strobes
//     SUB Eu   ALU subtract select and ALU output enable
//     HLT      halt indicator / clock-gate request
//     tstate   1..6 = T1..T6, 7 = WAIT, 0 = HALT
//
//   Every output is a Moore decode of the state register plus opcode.

module sap_sequencer #(
    parameter int ALU_LAT = 1   // legal 0..3
) (
    input  logic       CLK,
    input  logic       CLR_n,
    input  logic [3:0] opcode,
    output logic       Cp,
    output logic       Ep,
    output logic       Lm,
    output logic       CE,
    output logic       Li,
    output logic       Ei,
    output logic       La,
    output logic       Ea,
    output logic       Lb,
    output logic       Lo,
    output logic       SUB,
    output logic       Eu,
    output logic       HLT,
    output logic [2:0] tstate
);

    typedef enum logic [2:0] {
        S_HALT = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_T5   = 3'd5,
        S_T6   = 3'd6,
        S_WAIT = 3'd7
    } state_t;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // The counter is loaded with ALU_LAT-1 on entry to WAIT. WAIT is left on
    // the cycle the counter reads 0, so exactly ALU_LAT WAIT cycles occur.
    localparam logic [1:0] WAIT_INIT = (ALU_LAT > 0) ? 2'(ALU_LAT - 1) : 2'd0;
    localparam logic       USE_WAIT  = (ALU_LAT > 0);

    state_t     state, state_nx;
    logic [1:0] wait_cnt, wait_cnt_nx;

    logic is_lda, is_add, is_sub, is_out, is_hlt, is_alu;

    assign is_lda = (opcode == OP_LDA);
    assign is_add = (opcode == OP_ADD);
    assign is_sub = (opcode == OP_SUB);
    assign is_out = (opcode == OP_OUT);
    assign is_hlt = (opcode == OP_HLT);
    assign is_alu = is_add | is_sub;

    always_ff @(posedge CLK) begin
        if (!CLR_n) begin
            state    <= S_T1;
            wait_cnt <= 2'd0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        Cp  = 1'b0;
        Ep  = 1'b0;
        Lm  = 1'b0;
        CE  = 1'b0;
        Li  = 1'b0;
        Ei  = 1'b0;
        La  = 1'b0;
        Ea  = 1'b0;
        Lb  = 1'b0;
        Lo  = 1'b0;
        SUB = 1'b0;
        Eu  = 1'b0;
        HLT = 1'b0;

        case (state)
            S_T1: begin
                Ep       = 1'b1;
                Lm       = 1'b1;
                state_nx = S_T2;
            end
            S_T2: begin
                Cp       = 1'b1;
                state_nx = S_T3;
            end
            S_T3: begin
                CE       = 1'b1;
                Li       = 1'b1;
                state_nx = S_T4;
            end
            S_T4: begin
                if (is_lda || is_alu) begin
                    Ei = 1'b1;
                    Lm = 1'b1;
                end else if (is_out) begin
                    Ea = 1'b1;
                    Lo = 1'b1;
                end else if (is_hlt) begin
                    HLT = 1'b1;
                end
                state_nx = is_hlt ? S_HALT : S_T5;
            end
            S_T5: begin
                if (is_lda) begin
                    CE = 1'b1;
                    La = 1'b1;
                end else if (is_alu) begin
                    CE = 1'b1;
                    Lb = 1'b1;
                end
                // SUB rises here, one cycle before the ALU result is
                // captured, and stays up through T6.
                SUB = is_sub;
                if (is_alu && USE_WAIT) begin
                    state_nx    = S_WAIT;
                    wait_cnt_nx = WAIT_INIT;
                end else begin
                    state_nx = S_T6;
                end
            end
            S_WAIT: begin
                SUB = is_sub;
                if (wait_cnt == 2'd0) begin
                    state_nx = S_T6;
                end else begin
                    wait_cnt_nx = wait_cnt - 2'd1;
                end
            end
            S_T6: begin
                if (is_alu) begin
                    Eu = 1'b1;
                    La = 1'b1;
                end
                SUB      = is_sub;
                state_nx = S_T1;
            end
            S_HALT: begin
                // Only CLR_n leaves HALT.
                HLT = 1'b1;
            end
            default: state_nx = S_T1;
        endcase
    end

    assign tstate = state;

endmodule

// File: tb/tb_sap_sequencer.sv
// Directed bench for sap_sequencer. It uses one instance with ALU_LAT=1 and
// one with ALU_LAT=0. Strobes are packed as
// {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Lb,Lo,SUB,Eu,HLT} and compared with tstate after
// each rising edge.

module tb_sap_sequencer;

    localparam logic [12:0] CP = 13'h1000, EP = 13'h0800, LM = 13'h0400,
                            CE = 13'h0200, LI = 13'h0100, EI = 13'h0080,
                            LA = 13'h0040, EA = 13'h0020, LB = 13'h0010,
                            LO = 13'h0008, SB = 13'h0004, EU = 13'h0002,
                            HL = 13'h0001, NONE = 13'h0000;
    localparam logic [12:0] DRV = EP | CE | EI | EA | EU;

    logic       CLK = 1'b0;
    logic       clr1_n = 1'b0, clr0_n = 1'b0;
    logic [3:0] op1 = 4'b0001, op0 = 4'b0001;

    logic       Cp1, Ep1, Lm1, CE1, Li1, Ei1, La1, Ea1, Lb1, Lo1, SUB1, Eu1, HLT1;
    logic [2:0] t1;
    logic       Cp0, Ep0, Lm0, CE0, Li0, Ei0, La0, Ea0, Lb0, Lo0, SUB0, Eu0, HLT0;
    logic [2:0] t0;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    sap_sequencer #(.ALU_LAT(1)) u_dut1 (
        .CLK(CLK), .CLR_n(clr1_n), .opcode(op1),
        .Cp(Cp1), .Ep(Ep1), .Lm(Lm1), .CE(CE1), .Li(Li1), .Ei(Ei1), .La(La1),
        .Ea(Ea1), .Lb(Lb1), .Lo(Lo1), .SUB(SUB1), .Eu(Eu1), .HLT(HLT1),
        .tstate(t1)
    );

    sap_sequencer #(.ALU_LAT(0)) u_dut0 (
        .CLK(CLK), .CLR_n(clr0_n), .opcode(op0),
        .Cp(Cp0), .Ep(Ep0), .Lm(Lm0), .CE(CE0), .Li(Li0), .Ei(Ei0), .La(La0),
        .Ea(Ea0), .Lb(Lb0), .Lo(Lo0), .SUB(SUB0), .Eu(Eu0), .HLT(HLT0),
        .tstate(t0)
    );

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] ot, input logic [12:0] os,
                       input logic [2:0] et, input logic [12:0] es);
        checks++;
        assert ({ot, os} === {et, es}) else begin
            failures++;
            $error("FAIL %s tstate=%0d strobes=%b expected tstate=%0d strobes=%b",
                   tag, ot, os, et, es);
        end
        checks++;
        assert (($countones(os & DRV) <= 1) && !((os & LA) != 0 && (os & LB) != 0)) else begin
            failures++;
            $error("FAIL %s_invariant strobes=%b expected one driver max, no La+Lb", tag, os);
        end
    endtask

    task automatic c1(input string tag, input logic [2:0] et, input logic [12:0] es);
        chk(tag, t1, {Cp1, Ep1, Lm1, CE1, Li1, Ei1, La1, Ea1, Lb1, Lo1, SUB1, Eu1, HLT1}, et, es);
    endtask

    task automatic c0(input string tag, input logic [2:0] et, input logic [12:0] es);
        chk(tag, t0, {Cp0, Ep0, Lm0, CE0, Li0, Ei0, La0, Ea0, Lb0, Lo0, SUB0, Eu0, HLT0}, et, es);
    endtask

    initial begin
        // ---------------- ALU_LAT=1 instance ----------------
        cyc(); cyc();
        c1("rst_hold", 3'd1, EP | LM);
        clr1_n = 1'b1;
        // ADD: 1,2,3,4,5,7,6,1
        cyc(); c1("add_t2", 3'd2, CP);
        cyc(); c1("add_t3", 3'd3, CE | LI);
        cyc(); c1("add_t4", 3'd4, EI | LM);
        cyc(); c1("add_t5", 3'd5, CE | LB);
        cyc(); c1("add_wait", 3'd7, NONE);
        cyc(); c1("add_t6", 3'd6, EU | LA);
        cyc(); c1("add_next_t1", 3'd1, EP | LM);
        // SUB: the opcode changes during T1 and the fetch is unaffected.
        op1 = 4'b0010;
        c1("sub_t1", 3'd1, EP | LM);
        cyc(); c1("sub_t2", 3'd2, CP);
        cyc(); c1("sub_t3", 3'd3, CE | LI);
        cyc(); c1("sub_t4", 3'd4, EI | LM);
        cyc(); c1("sub_t5", 3'd5, CE | LB | SB);
        cyc(); c1("sub_wait", 3'd7, SB);
        cyc(); c1("sub_t6", 3'd6, EU | LA | SB);
        cyc(); c1("sub_next_t1", 3'd1, EP | LM);
        // LDA, changing the opcode in T2 to confirm the fetch ignores it.
        cyc(); op1 = 4'b1111; c1("lda_t2_opchg", 3'd2, CP);
        op1 = 4'b0000;
        cyc(); c1("lda_t3", 3'd3, CE | LI);
        cyc(); c1("lda_t4", 3'd4, EI | LM);
        cyc(); c1("lda_t5", 3'd5, CE | LA);
        cyc(); c1("lda_t6", 3'd6, NONE);
        cyc(); c1("lda_next_t1", 3'd1, EP | LM);
        // HLT
        op1 = 4'b1111;
        cyc(); c1("hlt_t2", 3'd2, CP);
        cyc(); c1("hlt_t3", 3'd3, CE | LI);
        cyc(); c1("hlt_t4", 3'd4, HL);
        for (int i = 0; i < 100; i++) begin
            cyc(); c1("hlt_hold", 3'd0, HL);
            op1 = 4'(i);
        end
        clr1_n = 1'b0;
        cyc(); c1("hlt_clr", 3'd1, EP | LM);
        clr1_n = 1'b1;
        // Reset in the middle of an ADD, at the edge that ends WAIT.
        op1 = 4'b0001;
        cyc(); c1("mid_t2", 3'd2, CP);
        cyc(); c1("mid_t3", 3'd3, CE | LI);
        cyc(); c1("mid_t4", 3'd4, EI | LM);
        cyc(); c1("mid_t5", 3'd5, CE | LB);
        cyc(); c1("mid_wait", 3'd7, NONE);
        clr1_n = 1'b0;
        cyc(); c1("mid_rst_t1", 3'd1, EP | LM);
        clr1_n = 1'b1;
        cyc(); c1("mid_after_t2", 3'd2, CP);

        // ---------------- ALU_LAT=0 instance ----------------
        c0("l0_rst_hold", 3'd1, EP | LM);
        clr0_n = 1'b1;
        cyc(); c0("l0_add_t2", 3'd2, CP);
        cyc(); c0("l0_add_t3", 3'd3, CE | LI);
        cyc(); c0("l0_add_t4", 3'd4, EI | LM);
        cyc(); c0("l0_add_t5", 3'd5, CE | LB);
        cyc(); c0("l0_add_t6", 3'd6, EU | LA);
        cyc(); c0("l0_add_t1", 3'd1, EP | LM);
        op0 = 4'b0101;
        cyc(); c0("l0_nop_t2", 3'd2, CP);
        cyc(); c0("l0_nop_t3", 3'd3, CE | LI);
        cyc(); c0("l0_nop_t4", 3'd4, NONE);
        cyc(); c0("l0_nop_t5", 3'd5, NONE);
        cyc(); c0("l0_nop_t6", 3'd6, NONE);
        cyc(); c0("l0_nop_t1", 3'd1, EP | LM);
        op0 = 4'b1110;
        cyc(); c0("l0_out_t2", 3'd2, CP);
        cyc(); c0("l0_out_t3", 3'd3, CE | LI);
        cyc(); c0("l0_out_t4", 3'd4, EA | LO);
        cyc(); c0("l0_out_t5", 3'd5, NONE);
        cyc(); c0("l0_out_t6", 3'd6, NONE);
        cyc(); c0("l0_out_t1", 3'd1, EP | LM);
        op0 = 4'b0010;
        cyc(); c0("l0_sub_t2", 3'd2, CP);
        cyc(); c0("l0_sub_t3", 3'd3, CE | LI);
        cyc(); c0("l0_sub_t4", 3'd4, EI | LM);
        cyc(); c0("l0_sub_t5", 3'd5, CE | LB | SB);
        cyc(); c0("l0_sub_t6", 3'd6, EU | LA | SB);
        cyc(); c0("l0_sub_t1", 3'd1, EP | LM);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sap_sequencer.md
Name: sap_sequencer

Overview:
- Controller/sequencer for the 8-bit bus computer; sits directly upstream of the add/subtract ALU.
- Steps through fetch and execute T-states and decodes the 4-bit opcode from the instruction register.
- Drives every bus load/enable strobe, including the ALU's SUB and OE inputs.
- Inserts wait states so the ALU's one-clock registered result settles before the accumulator loads it.

Parameters:
- ALU_LAT, 1, number of wait cycles between B-register load and accumulator load (legal 0..3).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- CLR_n  input  1  synchronous active-low reset; sampled on the rising edge of CLK.
- opcode  input  4  IR upper nibble; guaranteed stable from T4 until the end of the next T3.
- Cp  output  1  program counter increment.
- Ep  output  1  program counter drives the bus.
- Lm  output  1  MAR load.
- CE  output  1  RAM drives the bus.
- Li  output  1  IR load.
- Ei  output  1  IR address nibble drives the bus.
- La  output  1  accumulator load.
- Ea  output  1  accumulator drives the bus.
- Lb  output  1  B register load.
- Lo  output  1  output register load.
- SUB  output  1  to the ALU SUB input.
- Eu  output  1  to the ALU OE input.
- HLT  output  1  halt indicator / clock-gate request.
- tstate  output  3  state code: 1..6 = T1..T6, 7 = WAIT, 0 = HALT.

Behaviour:
- The only registers are the state register (T1..T6, WAIT, HALT) and a 2-bit wait counter.
- All outputs are a Moore decode of the state register plus opcode; there are no registered outputs.
- Reset: CLR_n=0 at a rising edge forces state=T1 and wait counter=0. This applies in any state, including mid-instruction, WAIT and HALT.
- Values during and immediately after reset: tstate=1, Ep=1, Lm=1, all other outputs 0.
- Opcodes:
  - LDA = 0000
  - ADD = 0001
  - SUB = 0010
  - OUT = 1110
  - HLT = 1111
  - all others = NOP
- Fetch, identical for every opcode:
  - T1: Ep, Lm.
  - T2: Cp.
  - T3: CE, Li.
- T4:
  - LDA/ADD/SUB: Ei, Lm.
  - OUT: Ea, Lo.
  - HLT: HLT=1, next state HALT.
  - NOP: no strobes.
- T5:
  - LDA: CE, La.
  - ADD/SUB: CE, Lb.
  - others: no strobes.
- Next state after T5:
  - ADD/SUB with ALU_LAT>0: WAIT, with wait counter loaded to ALU_LAT-1.
  - all other cases: T6.
- WAIT:
  - No load or enable strobes.
  - Decrements the wait counter each cycle; moves to T6 on the cycle the counter reads 0.
  - Total WAIT cycles = ALU_LAT.
- T6:
  - ADD/SUB: Eu, La.
  - others: no strobes.
  - Next state is always T1.
- SUB output:
  - =1 only for opcode SUB, and only in T5, every WAIT cycle, and T6.
  - =0 in all other states and for all other opcodes.
  - Held steady across the whole window so the ALU samples a stable value.
- Instruction length in cycles:
  - LDA / OUT / NOP: 6.
  - ADD / SUB: 6+ALU_LAT.
  - HLT: 4, then HALT.
- HALT:
  - HLT=1, tstate=0, all other outputs 0.
  - Remains in HALT until CLR_n=0, regardless of opcode.
- Invariants, all states:
  - At most one bus driver (Ep, CE, Ei, Ea, Eu) is active.
  - La and Lb are never asserted in the same cycle.
- An opcode change during T1–T3 has no effect on fetch strobes.

Test Plan:
- Reset: CLR_n=0 for 2 cycles, then 1 → tstate=1 with Ep=Lm=1, others 0; next cycles tstate=2 (Cp=1), then 3 (CE=Li=1).
- ADD (opcode=0001, ALU_LAT=1) → tstate 1,2,3,4,5,7,6,1:
  - T4: Ei, Lm.
  - T5: CE, Lb.
  - WAIT: no strobes.
  - T6: Eu, La.
  - SUB=0 throughout.
  - Next T1 on cycle 8.
- SUB (opcode=0010, ALU_LAT=1) → same sequence, with SUB=1 exactly in T5, WAIT and T6, and 0 in T1–T4. With the ALU attached, Acc=0x05 and B=0x07 → accumulator loads 0xFE.
- HLT (opcode=1111):
  - T4 asserts HLT; tstate=0 from the next cycle with HLT=1, all else 0.
  - Holds for 100 cycles with opcode toggling.
  - CLR_n=0 for one edge → tstate=1.
- Reset mid-op: ADD with CLR_n=0 at the edge ending WAIT → next tstate=1, La never pulses for that instruction.
- ALU_LAT=0 instance:
  - ADD → 6 cycles, T5→T6 direct, SUB=0.
  - opcode=0101 (NOP) → 6 cycles, no strobes in T4–T6.
  - OUT (1110) → Ea and Lo in T4 only.
